// File: rtl/branch_unit.sv
// Branch unit: RV32I branch condition evaluation with a registered decision
// and saturating statistics counters for evaluated and taken branches.
module branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       funct3,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic             branch_en,
  output logic             take_branch,
  output logic             invalid_funct3,
  output logic             take_branch_q,
  output logic [CNT_W-1:0] eval_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             operandsEqual;
  logic             signedLess;
  logic             unsignedLess;
  logic             takeBranch_q;
  logic [CNT_W-1:0] evalCount_q;
  logic [CNT_W-1:0] evalCount_d;
  logic [CNT_W-1:0] takenCount_q;
  logic [CNT_W-1:0] takenCount_d;

  // Shared comparators: one equality, one signed and one unsigned less-than.
  assign operandsEqual = (rs1_val == rs2_val);
  assign signedLess    = ($signed(rs1_val) < $signed(rs2_val));
  assign unsignedLess  = (rs1_val < rs2_val);

  // Decision is an and-or of decoded codes: unused codes give 0, and unknown
  // inputs propagate as X instead of silently falling into a default arm.
  always_comb begin
    take_branch = ((funct3 == 3'b000) &  operandsEqual)
                | ((funct3 == 3'b001) & ~operandsEqual)
                | ((funct3 == 3'b100) &  signedLess)
                | ((funct3 == 3'b101) & ~signedLess)
                | ((funct3 == 3'b110) &  unsignedLess)
                | ((funct3 == 3'b111) & ~unsignedLess);
  end

  // Codes 010 and 011 are not branch conditions in RV32I.
  assign invalid_funct3 = (funct3[2:1] == 2'b01);

  // Next counter values: count enabled cycles, saturating at all-ones.
  always_comb begin
    evalCount_d  = evalCount_q;
    takenCount_d = takenCount_q;
    if (branch_en) begin
      if (evalCount_q != CntMax) begin
        evalCount_d = evalCount_q + CntOne;
      end
      if (take_branch && (takenCount_q != CntMax)) begin
        takenCount_d = takenCount_q + CntOne;
      end
    end
  end

  // State registers; reset clears the registered decision and statistics at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      takeBranch_q <= 1'b0;
      evalCount_q  <= '0;
      takenCount_q <= '0;
    end else begin
      takeBranch_q <= take_branch;
      evalCount_q  <= evalCount_d;
      takenCount_q <= takenCount_d;
    end
  end

  assign take_branch_q = takeBranch_q;
  assign eval_count    = evalCount_q;
  assign taken_count   = takenCount_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: a 16-bit counter instance and a 4-bit
// counter instance share all inputs; expected values go through a queue.
module tb_branch_unit;

  logic        clk;
  logic        clkRun;
  logic        rst_n;
  logic [2:0]  funct3;
  logic [31:0] rs1Val;
  logic [31:0] rs2Val;
  logic        branchEn;

  logic        takeBranch;
  logic        invalidFunct3;
  logic        takeBranchQ;
  logic [15:0] evalCount;
  logic [15:0] takenCount;

  logic        takeBranchS;
  logic        invalidFunct3S;
  logic        takeBranchQS;
  logic [3:0]  evalCountS;
  logic [3:0]  takenCountS;

  int checks;
  int errors;

  // Expected single-bit results, pushed when stimulus is driven.
  logic expQ[$];

  // Bench-side counter model for both instances.
  int evalExp;
  int takenExp;
  int evalExpS;
  int takenExpS;

  branch_unit #(.CNT_W(16)) dutDefault (
    .clk           (clk),
    .rst_n         (rst_n),
    .funct3        (funct3),
    .rs1_val       (rs1Val),
    .rs2_val       (rs2Val),
    .branch_en     (branchEn),
    .take_branch   (takeBranch),
    .invalid_funct3(invalidFunct3),
    .take_branch_q (takeBranchQ),
    .eval_count    (evalCount),
    .taken_count   (takenCount)
  );

  branch_unit #(.CNT_W(4)) dutSmall (
    .clk           (clk),
    .rst_n         (rst_n),
    .funct3        (funct3),
    .rs1_val       (rs1Val),
    .rs2_val       (rs2Val),
    .branch_en     (branchEn),
    .take_branch   (takeBranchS),
    .invalid_funct3(invalidFunct3S),
    .take_branch_q (takeBranchQS),
    .eval_count    (evalCountS),
    .taken_count   (takenCountS)
  );

  // Gated clock so that combinational checks can run with no edges at all.
  initial clk = 1'b0;
  always #5 if (clkRun) clk = ~clk;

  // Reference branch decision from the RV32I definitions.
  function automatic logic modelTake(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the counter model by one rising edge.
  function automatic void modelEdge(input logic en, input logic tk);
    if (en) begin
      if (evalExp < 65535) evalExp++;
      if (evalExpS < 15) evalExpS++;
      if (tk) begin
        if (takenExp < 65535) takenExp++;
        if (takenExpS < 15) takenExpS++;
      end
    end
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    evalExp = 0;
    takenExp = 0;
    evalExpS = 0;
    takenExpS = 0;
    expQ.delete();
  endtask

  task automatic test_reset();
    logic exp;
    clkRun = 1'b0;
    rst_n = 1'b1;
    funct3 = 3'b000;
    rs1Val = 32'd7;
    rs2Val = 32'd7;
    branchEn = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (takeBranchQ !== 1'b0 || evalCount !== 16'd0 || takenCount !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_clear q=%b eval=%0d taken=%0d expected 0/0/0", takeBranchQ, evalCount, takenCount);
    end
    expQ.push_back(1'b1);
    exp = expQ.pop_front();
    checks++;
    if (takeBranch !== exp) begin
      errors++;
      $display("[TB] FAIL reset_comb take_branch=%b expected=%b", takeBranch, exp);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_beq_bne();
    logic [31:0] aT[2] = '{32'h10, 32'h10};
    logic [31:0] bT[2] = '{32'h10, 32'h11};
    logic        eqT[2] = '{1'b1, 1'b0};
    logic        exp;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        funct3 = (k == 0) ? 3'b000 : 3'b001;
        rs1Val = aT[i];
        rs2Val = bT[i];
        expQ.push_back((k == 0) ? eqT[i] : ~eqT[i]);
        #1;
        exp = expQ.pop_front();
        checks++;
        if (takeBranch !== exp || invalidFunct3 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL beq_bne[%0d] f=%b take=%b inv=%b expected take=%b inv=0", i, funct3, takeBranch, invalidFunct3, exp);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [2:0]  fT[5] = '{3'b100, 3'b101, 3'b100, 3'b101, 3'b101};
    logic [31:0] aT[5] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFF6, 32'd5, 32'hFFFFFFFB};
    logic [31:0] bT[5] = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'd5, 32'hFFFFFFF6};
    logic        eT[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp;
    clkRun = 1'b0;
    for (int i = 0; i < 5; i++) begin
      funct3 = fT[i];
      rs1Val = aT[i];
      rs2Val = bT[i];
      expQ.push_back(eT[i]);
      #1;
      exp = expQ.pop_front();
      checks++;
      if (takeBranch !== exp) begin
        errors++;
        $display("[TB] FAIL signed[%0d] f=%b a=%h b=%h take=%b expected=%b", i, funct3, rs1Val, rs2Val, takeBranch, exp);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [2:0]  fT[6] = '{3'b110, 3'b111, 3'b110, 3'b111, 3'b100, 3'b110};
    logic [31:0] aT[6] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bT[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd10, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic        eT[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        exp;
    for (int i = 0; i < 6; i++) begin
      funct3 = fT[i];
      rs1Val = aT[i];
      rs2Val = bT[i];
      expQ.push_back(eT[i]);
      #1;
      exp = expQ.pop_front();
      checks++;
      if (takeBranch !== exp) begin
        errors++;
        $display("[TB] FAIL unsigned[%0d] f=%b a=%h b=%h take=%b expected=%b", i, funct3, rs1Val, rs2Val, takeBranch, exp);
      end
    end
  endtask

  task automatic test_invalid();
    logic [2:0] fT[2] = '{3'b010, 3'b011};
    logic       exp;
    for (int i = 0; i < 2; i++) begin
      funct3 = fT[i];
      rs1Val = 32'd1;
      rs2Val = 32'd1;
      expQ.push_back(1'b0);
      #1;
      exp = expQ.pop_front();
      checks++;
      if (takeBranch !== exp || invalidFunct3 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL invalid[%0d] take=%b inv=%b expected take=%b inv=1", i, takeBranch, invalidFunct3, exp);
      end
    end
  endtask

  task automatic test_counters();
    logic [2:0]  fT[4] = '{3'b000, 3'b000, 3'b001, 3'b000};
    logic [31:0] bT[4] = '{32'd3, 32'd4, 32'd4, 32'd3};
    logic        enT[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp;
    clkRun = 1'b1;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      funct3 = fT[i];
      rs1Val = 32'd3;
      rs2Val = bT[i];
      branchEn = enT[i];
      expQ.push_back(modelTake(fT[i], 32'd3, bT[i]));
      modelEdge(enT[i], modelTake(fT[i], 32'd3, bT[i]));
      @(posedge clk);
      #1;
      exp = expQ.pop_front();
      checks++;
      if (takeBranchQ !== exp) begin
        errors++;
        $display("[TB] FAIL counters_lag[%0d] take_branch_q=%b expected=%b", i, takeBranchQ, exp);
      end
    end
    checks++;
    if (evalCount !== 16'd3 || takenCount !== 16'd2) begin
      errors++;
      $display("[TB] FAIL counters_total eval=%0d taken=%0d expected 3/2", evalCount, takenCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic        exp;
    applyReset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      en = 1'($urandom_range(0, 1));
      funct3 = f;
      rs1Val = a;
      rs2Val = b;
      branchEn = en;
      expQ.push_back(modelTake(f, a, b));
      modelEdge(en, modelTake(f, a, b));
      @(posedge clk);
      #1;
      exp = expQ.pop_front();
      checks++;
      if (takeBranchQ !== exp || takeBranchQS !== exp) begin
        errors++;
        $display("[TB] FAIL b2b[%0d] f=%b q=%b qs=%b expected=%b", i, f, takeBranchQ, takeBranchQS, exp);
      end
    end
    checks++;
    if (evalCount !== 16'(evalExp) || takenCount !== 16'(takenExp)
        || evalCountS !== 4'(evalExpS) || takenCountS !== 4'(takenExpS)) begin
      errors++;
      $display("[TB] FAIL b2b_counts eval=%0d taken=%0d evalS=%0d takenS=%0d expected %0d/%0d/%0d/%0d",
               evalCount, takenCount, evalCountS, takenCountS, evalExp, takenExp, evalExpS, takenExpS);
    end
  endtask

  task automatic test_saturation();
    applyReset();
    @(negedge clk);
    funct3 = 3'b000;
    rs1Val = 32'd9;
    rs2Val = 32'd9;
    branchEn = 1'b1;
    repeat (20) begin
      modelEdge(1'b1, modelTake(3'b000, 32'd9, 32'd9));
      @(posedge clk);
    end
    #1;
    checks++;
    if (evalCountS !== 4'd15 || takenCountS !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_small eval=%0d taken=%0d expected 15/15", evalCountS, takenCountS);
    end
    checks++;
    if (evalCount !== 16'(evalExp) || takenCount !== 16'(takenExp)) begin
      errors++;
      $display("[TB] FAIL sat_default eval=%0d taken=%0d expected %0d/%0d", evalCount, takenCount, evalExp, takenExp);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (evalCount !== 16'd0 || takenCount !== 16'd0 || evalCountS !== 4'd0
        || takenCountS !== 4'd0 || takeBranchQ !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear eval=%0d taken=%0d evalS=%0d takenS=%0d q=%b expected all 0",
               evalCount, takenCount, evalCountS, takenCountS, takeBranchQ);
    end
    checks++;
    if (takeBranch !== 1'b1 || invalidFunct3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_comb take=%b inv=%b expected 1/0", takeBranch, invalidFunct3);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (evalCount !== 16'd1 || takenCount !== 16'd1 || takeBranchQ !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume eval=%0d taken=%0d q=%b expected 1/1/1", evalCount, takenCount, takeBranchQ);
    end
    @(negedge clk);
    branchEn = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_beq_bne();
    test_signed();
    test_unsigned();
    test_invalid();
    test_counters();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover entries=%0d expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters.
REQ-002 Port clk, input, 1: single clock for all registered state.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port funct3, input, 3: RV32I branch condition code.
REQ-005 Port rs1_val, input, 32: first source operand.
REQ-006 Port rs2_val, input, 32: second source operand.
REQ-007 Port branch_en, input, 1: marks the current cycle as a branch instruction, for statistics only.
REQ-008 Port take_branch, output, 1: combinational branch decision.
REQ-009 Port invalid_funct3, output, 1: combinational flag; funct3 is 010 or 011.
REQ-010 Port take_branch_q, output, 1: registered copy of take_branch.
REQ-011 Port eval_count, output, CNT_W: number of cycles in which branch_en was high.
REQ-012 Port taken_count, output, CNT_W: number of cycles in which branch_en and take_branch were both high.

Function
REQ-013 take_branch SHALL be purely combinational from funct3, rs1_val and rs2_val, with no dependence on clk, rst_n or branch_en.
REQ-014 take_branch SHALL be valid within the same delta and need no clock edge.
REQ-015 funct3 000 (BEQ): take_branch SHALL be 1 when rs1_val == rs2_val.
REQ-016 funct3 001 (BNE): take_branch SHALL be 1 when rs1_val != rs2_val.
REQ-017 funct3 100 (BLT): take_branch SHALL be 1 when rs1_val < rs2_val, compared as 32-bit two's-complement.
REQ-018 funct3 101 (BGE): take_branch SHALL be 1 when rs1_val >= rs2_val, signed.
REQ-019 funct3 110 (BLTU): take_branch SHALL be 1 when rs1_val < rs2_val, unsigned.
REQ-020 funct3 111 (BGEU): take_branch SHALL be 1 when rs1_val >= rs2_val, unsigned.
REQ-021 funct3 010 or 011: take_branch SHALL be 0 and invalid_funct3 SHALL be 1.
REQ-022 For every other funct3 value, invalid_funct3 SHALL be 0.
REQ-023 Signed and unsigned results SHALL differ when the operand sign bits differ.
  - Example: 0x80000000 vs 0x7FFFFFFF gives BLT = 1 and BLTU = 0.
REQ-024 X or Z on any input bit SHALL NOT be masked; no latch SHALL be inferred, and a default branch SHALL drive 0.
REQ-025 take_branch_q SHALL load take_branch on every rising clk edge, one cycle of latency.
REQ-026 On a rising edge with branch_en = 1:
  - eval_count SHALL increment by 1;
  - taken_count SHALL also increment by 1 if take_branch = 1.
REQ-027 Both counters SHALL saturate at all-ones and never wrap.
REQ-028 Invalid funct3 with branch_en = 1 SHALL increment eval_count only.

Reset
REQ-029 While rst_n = 0, take_branch_q, eval_count and taken_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 Reset SHALL NOT affect take_branch or invalid_funct3.
REQ-031 Counting SHALL resume on the first rising edge after rst_n deasserts.
REQ-032 Reset asserted mid-count SHALL discard the accumulated counts.

Verification
REQ-033 BEQ/BNE: 0x10 vs 0x10 gives BEQ = 1, BNE = 0; 0x10 vs 0x11 gives BEQ = 0, BNE = 1.
REQ-034 BLT/BGE signed, each case checked with no clock running:
  - -5 (0xFFFFFFFB) vs 5 gives BLT = 1, BGE = 0;
  - -10 vs -5 gives BLT = 1;
  - 5 vs 5 gives BGE = 1;
  - -5 vs -10 gives BGE = 1.
REQ-035 Unsigned:
  - 0x80000000 vs 0x7FFFFFFF gives BLTU = 0, BGEU = 1;
  - 0x7FFFFFFF vs 0x80000000 gives BLTU = 1;
  - 5 vs 10 gives BGEU = 0.
REQ-036 funct3 = 010 with 1 vs 1 gives take_branch = 0, invalid_funct3 = 1.
REQ-037 Counters and registered output:
  - sequence: reset, then 3 cycles with branch_en = 1 (BEQ equal, BEQ unequal, BNE unequal), then 1 cycle with branch_en = 0;
  - eval_count SHALL be 3 and taken_count SHALL be 2;
  - take_branch_q SHALL lag take_branch by one cycle.
REQ-038 Saturation and async reset:
  - with CNT_W = 4 and branch_en held high with a taken branch for 20 cycles, both counters SHALL hold at 15;
  - asserting rst_n low between clock edges SHALL clear both counters at once.
